// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage: shift-add multiplier,
// restoring divider, HI/LO ownership and the MFHI/MFLO stall.
module ex_muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic             hiloRead,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   work_hi, work_lo, operand;
    logic               is_div, neg_a, neg_b;
    logic               accept, is_signed, sign1, sign2;
    logic [WIDTH-1:0]   abs1, abs2, addend, div_rem;
    logic [WIDTH:0]     mult_sum, div_shift;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    assign busy      = (state != IDLE);
    assign stall     = hiloRead & busy;
    assign accept    = (state == IDLE) & start & ~flush;
    assign is_signed = ~mdOp[0];
    assign sign1     = is_signed & reg1[WIDTH-1];
    assign sign2     = is_signed & reg2[WIDTH-1];
    assign abs1      = sign1 ? -reg1 : reg1;
    assign abs2      = sign2 ? -reg2 : reg2;

    // work_hi/work_lo hold {product} for multiply and {remainder, quotient} for
    // divide; operand is the multiplicand or the divisor magnitude.
    assign addend     = work_lo[0] ? operand : '0;
    assign mult_sum   = {1'b0, work_hi} + {1'b0, addend};
    assign div_shift  = {work_hi, work_lo[WIDTH-1]};
    assign div_ok     = (div_shift >= {1'b0, operand});
    assign div_rem    = div_shift[WIDTH-1:0] - operand;

    assign prod_fixed = (neg_a ^ neg_b) ? -{work_hi, work_lo} : {work_hi, work_lo};
    assign quot_fixed = (neg_a ^ neg_b) ? -work_lo : work_lo;
    assign rem_fixed  = neg_a ? -work_hi : work_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN: begin
                if (flush)                         state_nx = IDLE;
                else if (count == CW'(WIDTH - 1))  state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            work_hi <= '0;
            work_lo <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
            hiOut   <= '0;
            loOut   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div  <= mdOp[1];
                        neg_a   <= sign1;
                        neg_b   <= sign2;
                        count   <= '0;
                        divZero <= mdOp[1] & (reg2 == '0);
                        work_hi <= '0;
                        if (mdOp[1]) begin
                            operand <= abs2;
                            work_lo <= abs1;
                        end else begin
                            operand <= abs1;
                            work_lo <= abs2;
                        end
                    end else begin
                        if (hiWrite) hiOut <= reg1;
                        if (loWrite) loOut <= reg1;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        count <= count + 1'b1;
                        if (is_div) begin
                            work_hi <= div_ok ? div_rem : div_shift[WIDTH-1:0];
                            work_lo <= {work_lo[WIDTH-2:0], div_ok};
                        end else begin
                            {work_hi, work_lo} <= {mult_sum, work_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hiOut <= rem_fixed;
                            loOut <= quot_fixed;
                        end else begin
                            {hiOut, loOut} <= prod_fixed;
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: random and directed MULT/DIV
// traffic compared with an arithmetic reference model, plus control scenarios.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mdOp = '0;
    logic [W-1:0] reg1 = '0;
    logic [W-1:0] reg2 = '0;
    logic         hiWrite = 1'b0;
    logic         loWrite = 1'b0;
    logic         hiloRead = 1'b0;
    logic         flush = 1'b0;
    logic         busy, stall, done, divZero;
    logic [W-1:0] hiOut, loOut;

    int total = 0;
    int bad   = 0;

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
        .reg1(reg1), .reg2(reg2), .hiWrite(hiWrite), .loWrite(loWrite),
        .hiloRead(hiloRead), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .divZero(divZero), .hiOut(hiOut), .loOut(loOut)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; divide-by-zero per the documented rules.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = op[1] && (b == 32'd0);
        p  = '0;
        h  = '0;
        l  = '0;
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    h = a;
                    l = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
        if (!op[1]) begin
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp  = op;
        reg1  = a;
        reg2  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        hiloRead = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        total++; if (stall !== 1'b0)   begin bad++; $display("FAIL reset stall got=%b want=0", stall); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset done got=%b want=0", done); end
        total++; if (divZero !== 1'b0) begin bad++; $display("FAIL reset divZero got=%b want=0", divZero); end
        total++; if (hiOut !== '0)     begin bad++; $display("FAIL reset hi got=%h want=0", hiOut); end
        total++; if (loOut !== '0)     begin bad++; $display("FAIL reset lo got=%h want=0", loOut); end
        hiloRead = 1'b0;
        reset    = 1'b1;
        tick();
    endtask

    task automatic test_hilo_write();
        logic [31:0] x, y, eh, el;
        logic ez;
        int lat;
        x = $urandom();
        y = $urandom();
        reg1 = x; hiWrite = 1'b1; tick(); hiWrite = 1'b0;
        total++; if (hiOut !== x) begin bad++; $display("FAIL mthi got=%h want=%h", hiOut, x); end
        reg1 = y; loWrite = 1'b1; tick(); loWrite = 1'b0;
        total++; if (loOut !== y) begin bad++; $display("FAIL mtlo got=%h want=%h", loOut, y); end
        total++; if (hiOut !== x) begin bad++; $display("FAIL mtlo_keep_hi got=%h want=%h", hiOut, x); end
        hiloRead = 1'b1; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", stall); end
        hiloRead = 1'b0;
        // start together with MTHI/MTLO: the writes must be dropped
        model(2'd1, 32'd3, 32'd5, eh, el, ez);
        hiWrite = 1'b1; loWrite = 1'b1;
        issue(2'd1, 32'd3, 32'd5);
        hiWrite = 1'b0; loWrite = 1'b0;
        total++; if (hiOut !== x) begin bad++; $display("FAIL start_wins hi got=%h want=%h", hiOut, x); end
        total++; if (loOut !== y) begin bad++; $display("FAIL start_wins lo got=%h want=%h", loOut, y); end
        wait_done(lat);
        total++; if (lat != 33)    begin bad++; $display("FAIL start_wins lat got=%0d want=33", lat); end
        total++; if (hiOut !== eh) begin bad++; $display("FAIL start_wins res_hi got=%h want=%h", hiOut, eh); end
        total++; if (loOut !== el) begin bad++; $display("FAIL start_wins res_lo got=%h want=%h", loOut, el); end
    endtask

    task automatic test_arith();
        logic [1:0]  d_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [31:0] d_a  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'd6,
                                  32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] d_b  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'd3,
                                  32'hFFFF_FFFF, 32'd0};
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        logic ez;
        int lat;
        for (int i = 0; i < 32; i++) begin
            if (i < 8) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i];
            end else begin
                op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
            end
            model(op, a, b, eh, el, ez);
            issue(op, a, b);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL arith[%0d] busy got=%b want=1", i, busy); end
            wait_done(lat);
            total++; if (lat != 33) begin bad++; $display("FAIL arith[%0d] lat got=%0d want=33", i, lat); end
            total++;
            if (hiOut !== eh || loOut !== el) begin
                bad++;
                $display("FAIL arith[%0d] op=%0d a=%h b=%h hi/lo got=%h/%h want=%h/%h", i, op, a, b, hiOut, loOut, eh, el);
            end
            total++; if (divZero !== ez) begin bad++; $display("FAIL arith[%0d] divZero got=%b want=%b", i, divZero, ez); end
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL arith[%0d] done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
        logic z1, z2;
        int lat;
        a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
        model(2'd0, a1, b1, h1, l1, z1);
        model(2'd3, a2, b2, h2, l2, z2);
        issue(2'd0, a1, b1);
        wait_done(lat);
        total++; if (hiOut !== h1 || loOut !== l1) begin bad++; $display("FAIL b2b first got=%h/%h want=%h/%h", hiOut, loOut, h1, l1); end
        issue(2'd3, a2, b2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b accept busy got=%b want=1", busy); end
        wait_done(lat);
        total++; if (lat != 33) begin bad++; $display("FAIL b2b lat got=%0d want=33", lat); end
        total++; if (hiOut !== h2 || loOut !== l2) begin bad++; $display("FAIL b2b second got=%h/%h want=%h/%h", hiOut, loOut, h2, l2); end
        total++; if (divZero !== z2) begin bad++; $display("FAIL b2b divZero got=%b want=%b", divZero, z2); end
    endtask

    task automatic test_start_busy();
        logic [31:0] a, b, eh, el;
        logic ez;
        int lat;
        a = $urandom(); b = 32'($urandom_range(1, 1000));
        model(2'd3, a, b, eh, el, ez);
        issue(2'd3, a, b);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start = 1'b1; mdOp = 2'd0; reg1 = $urandom(); reg2 = 32'd0;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++; if (lat != 33) begin bad++; $display("FAIL busy_start lat got=%0d want=33", lat); end
        total++; if (hiOut !== eh || loOut !== el) begin bad++; $display("FAIL busy_start res got=%h/%h want=%h/%h", hiOut, loOut, eh, el); end
        total++; if (divZero !== ez) begin bad++; $display("FAIL busy_start divZero got=%b want=%b", divZero, ez); end
    endtask

    task automatic test_stall();
        logic [31:0] a, b, eh, el;
        logic ez, want;
        int lat;
        a = $urandom(); b = $urandom();
        model(2'd0, a, b, eh, el, ez);
        issue(2'd0, a, b);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            hiloRead = (k >= 3);
            hiWrite  = (k == 10);
            if (k == 10) reg1 = 32'hDEAD_BEEF;
            #1;
            want = (k >= 3 && k <= 32);
            total++; if (stall !== want) begin bad++; $display("FAIL stall cycle=%0d got=%b want=%b", k, stall, want); end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        hiloRead = 1'b0;
        hiWrite  = 1'b0;
        total++; if (lat != 33) begin bad++; $display("FAIL stall lat got=%0d want=33", lat); end
        total++; if (hiOut !== eh || loOut !== el) begin bad++; $display("FAIL stall_mthi res got=%h/%h want=%h/%h", hiOut, loOut, eh, el); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] a, b, ph, pl;
        logic pz;
        int lat, cnt;
        a = $urandom(); b = $urandom();
        model(2'd1, a, b, ph, pl, pz);
        issue(2'd1, a, b);
        wait_done(lat);
        total++; if (hiOut !== ph || loOut !== pl) begin bad++; $display("FAIL flush_prior got=%h/%h want=%h/%h", hiOut, loOut, ph, pl); end
        issue(2'd2, $urandom(), 32'd0);
        for (int k = 1; k <= 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL flush busy got=%b want=0", busy); end
        total++; if (hiOut !== ph)     begin bad++; $display("FAIL flush hi got=%h want=%h", hiOut, ph); end
        total++; if (loOut !== pl)     begin bad++; $display("FAIL flush lo got=%h want=%h", loOut, pl); end
        total++; if (divZero !== 1'b1) begin bad++; $display("FAIL flush divZero got=%b want=1", divZero); end
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        total++; if (cnt != 0) begin bad++; $display("FAIL flush no_done got=%0d want=0", cnt); end
        mdOp = 2'd0; reg1 = 32'd9; reg2 = 32'd9;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_start busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] eh, el;
        logic ez;
        int lat;
        issue(2'd0, $urandom(), $urandom());
        for (int k = 1; k <= 5; k++) tick();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy got=%b want=0", busy); end
        total++; if (hiOut !== '0)  begin bad++; $display("FAIL midreset hi got=%h want=0", hiOut); end
        total++; if (loOut !== '0)  begin bad++; $display("FAIL midreset lo got=%h want=0", loOut); end
        tick();
        reset = 1'b1;
        tick();
        model(2'd3, 32'd100, 32'd7, eh, el, ez);
        issue(2'd3, 32'd100, 32'd7);
        wait_done(lat);
        total++; if (lat != 33) begin bad++; $display("FAIL midreset recover lat got=%0d want=33", lat); end
        total++; if (hiOut !== eh || loOut !== el) begin bad++; $display("FAIL midreset recover got=%h/%h want=%h/%h", hiOut, loOut, eh, el); end
    endtask

    initial begin
        test_reset();
        test_hilo_write();
        test_arith();
        test_back_to_back();
        test_start_busy();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
